// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard receiver for the pCPU I/O bus.
// Raw kclk/kdata are synchronised and glitch-filtered, an 11-bit frame FSM
// assembles bytes, E0/F0 prefixes are folded into one event per key, and
// events are queued in a FIFO read through a 4-word register window.
// Optional feature macro: PS2_PARITY_CHK_EN (drop frames with bad odd parity
// and report them in perr). Without it perr reads 0.
module ps2_kbd_ctrl #(
  parameter int FILT     = 8,
  parameter int TIMEOUT  = 50000,
  parameter int DEPTH_LG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kclk,
  input  logic        kdata,
  input  logic [1:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        irq
);
  localparam int DEPTH = 1 << DEPTH_LG;
  localparam int FW    = $clog2(FILT);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int CW    = DEPTH_LG + 1;

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          kclk_sync, kdata_sync;
  logic [FW-1:0]       kclk_cnt, kdata_cnt;
  logic                kclk_filt, kdata_filt, kclk_prev, fall;
  logic [TW-1:0]       to_cnt;
  logic                timeout;
  logic [7:0]          shift;
  logic [2:0]          bit_cnt;
  logic                stop_edge, parity_ok, accept;
  logic                acc_valid;
  logic [7:0]          acc_byte;
  logic                ext, brk, push, flush, pop, do_push, push_drop;
  logic [9:0]          mem [DEPTH];
  logic [DEPTH_LG-1:0] wptr, rptr;
  logic [CW-1:0]       count;
  logic                empty, full;
  logic                ovf, ferr, perr, ie;
  logic                stat_we;
  logic                unused_bits;

  // Two-flop synchronisers; PS/2 lines idle high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kclk_sync  <= 2'b11;
      kdata_sync <= 2'b11;
    end else begin
      kclk_sync  <= {kclk_sync[0], kclk};
      kdata_sync <= {kdata_sync[0], kdata};
    end
  end

  // kclk filter: follow the synchronised line only after FILT stable cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kclk_filt <= 1'b1;
      kclk_cnt  <= '0;
    end else if (kclk_sync[1] == kclk_filt) begin
      kclk_cnt <= '0;
    end else if (kclk_cnt == FW'(FILT - 1)) begin
      kclk_filt <= kclk_sync[1];
      kclk_cnt  <= '0;
    end else begin
      kclk_cnt <= kclk_cnt + 1'b1;
    end
  end

  // kdata filter, same rule as kclk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kdata_filt <= 1'b1;
      kdata_cnt  <= '0;
    end else if (kdata_sync[1] == kdata_filt) begin
      kdata_cnt <= '0;
    end else if (kdata_cnt == FW'(FILT - 1)) begin
      kdata_filt <= kdata_sync[1];
      kdata_cnt  <= '0;
    end else begin
      kdata_cnt <= kdata_cnt + 1'b1;
    end
  end

  assign fall      = kclk_prev & ~kclk_filt;
  assign timeout   = (state_q != IDLE) && (to_cnt == TW'(TIMEOUT - 1));
  assign stop_edge = fall && (state_q == STOP);
  assign accept    = stop_edge && kdata_filt && parity_ok;

  // Frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Frame next-state: advance on falling edges, abandon a stalled frame
  always_comb begin
    state_d = state_q;
    if (fall) begin
      case (state_q)
        IDLE:    if (!kdata_filt) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PAR;
        PAR:     state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  // Edge detect, stall counter, shift register and accepted-byte stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kclk_prev <= 1'b1;
      to_cnt    <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      acc_valid <= 1'b0;
      acc_byte  <= '0;
    end else begin
      kclk_prev <= kclk_filt;
      if (fall || state_q == IDLE) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
      if (fall && state_q == IDLE) bit_cnt <= '0;
      if (fall && state_q == DATA) begin
        shift   <= {kdata_filt, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      acc_valid <= accept;
      if (accept) acc_byte <= shift;
    end
  end

`ifdef PS2_PARITY_CHK_EN
  logic par_bit;

  assign parity_ok   = (par_bit == ~^shift);
  assign unused_bits = ^d[31:5];

  // Parity capture and parity-error flag (set wins over a same-cycle clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit <= 1'b0;
      perr    <= 1'b0;
    end else begin
      if (fall && state_q == PAR) par_bit <= kdata_filt;
      if (stop_edge && kdata_filt && !parity_ok) perr <= 1'b1;
      else if (stat_we && d[3])                  perr <= 1'b0;
    end
  end
`else
  assign parity_ok   = 1'b1;
  assign perr        = 1'b0;
  assign unused_bits = ^{d[31:5], d[3]};
`endif

  assign stat_we   = we && (a == 2'd1);
  assign flush     = we && (a == 2'd2) && d[1];
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = rd && (a == 2'd0) && !empty;
  assign push      = acc_valid && (acc_byte != 8'hE0) && (acc_byte != 8'hF0);
  assign do_push   = push && !flush && (!full || pop);
  assign push_drop = push && !flush && full && !pop;

  // Prefix folding: E0/F0 arm ext/brk, any other byte consumes them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (flush) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (acc_valid) begin
      if (acc_byte == 8'hE0) begin
        ext <= 1'b1;
      end else if (acc_byte == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset because reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= {ext, brk, acc_byte};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
    end
  end

  // Sticky error flags, interrupt enable and registered interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf  <= 1'b0;
      ferr <= 1'b0;
      ie   <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (push_drop)            ovf <= 1'b1;
      else if (stat_we && d[2]) ovf <= 1'b0;
      if (stop_edge && !kdata_filt) ferr <= 1'b1;
      else if (stat_we && d[4])     ferr <= 1'b0;
      if (we && a == 2'd2) ie <= d[0];
      irq <= ie & ~empty;
    end
  end

  // Register window read mux
  always_comb begin
    spo = '0;
    case (a)
      2'd0:    if (!empty) spo = {1'b1, 21'b0, mem[rptr]};
      2'd1:    spo = {16'b0, 8'(count), 3'b0, ferr, perr, ovf, empty, full};
      2'd2:    spo = {31'b0, ie};
      default: spo = '0;
    endcase
  end
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: drives PS/2 frames into ps2_kbd_ctrl and compares the
// decoded key events and status flags with a behavioural keyboard model.
module tb_ps2_kbd_ctrl;
  localparam int TOUT  = 400;
  localparam int DEPTH = 16;
  localparam int HALF  = 203;

  logic        clk, rst, kclk, kdata, we, irq;
  logic [1:0]  a, stim_a, mon_a;
  logic        rd, stim_rd, mon_rd;
  logic        mon_en, mon_busy;
  logic [31:0] d, spo;

  logic [31:0] sb_q[$];
  logic        m_ext, m_brk, m_ovf, m_ferr, m_perr;
  int          tests, fails;

  assign a  = mon_busy ? mon_a  : stim_a;
  assign rd = mon_busy ? mon_rd : stim_rd;

  ps2_kbd_ctrl #(.FILT(8), .TIMEOUT(TOUT), .DEPTH_LG(4)) dut (
    .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata), .a(a), .d(d),
    .we(we), .rd(rd), .spo(spo), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Keyboard model: what the register window should show for the bytes sent
  task automatic modelReset();
    sb_q.delete();
    m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic modelByte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (sb_q.size() >= DEPTH) m_ovf = 1'b1;
      else sb_q.push_back({1'b1, 21'b0, m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  function automatic logic [31:0] expStatus();
    int n = sb_q.size();
    return {16'b0, 8'(n), 3'b0, m_ferr, m_perr, m_ovf, n == 0, n == DEPTH};
  endfunction

  // Clocks out the first nbits of a frame: start, 8 data LSB first, odd parity, stop
  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kdata = fr[i];
      #HALF kclk = 1'b0;
      #HALF kclk = 1'b1;
    end
    kdata = 1'b1;
    #(HALF * 2);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop) m_ferr = 1'b1;
`ifdef PS2_PARITY_CHK_EN
    else if (bad_par) m_perr = 1'b1;
`endif
    else modelByte(b);
    applyStimulus(b, bad_par, bad_stop, 11);
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] val);
    @(negedge clk);
    stim_a = addr;
    #1 val = spo;
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] val);
    @(negedge clk);
    stim_a = addr; d = val; we = 1'b1;
    @(negedge clk);
    we = 1'b0; d = '0;
  endtask

  task automatic checkStatus(input string name);
    logic [31:0] v;
    busRead(2'd1, v);
    checkOutput(name, v, expStatus());
  endtask

  task automatic pauseMonitor();
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Let the reader empty the FIFO, bounded in cycles
  task automatic drain();
    int n = 0;
    mon_en = 1'b1;
    while ((sb_q.size() != 0 || irq) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    pauseMonitor();
    if (n >= 3000) checkOutput("drain_timeout", 32'(sb_q.size()), 32'h0);
  endtask

  // Reader: pops one DATA word whenever the interrupt is raised
  initial begin
    logic [31:0] got, exp_v;
    mon_busy = 1'b0; mon_a = 2'd0; mon_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && irq && rst) begin
        mon_busy = 1'b1; mon_a = 2'd0; mon_rd = 1'b1;
        #1 got = spo;
        if (sb_q.size() == 0) checkOutput("unexpected_entry", got, 32'h0);
        else begin
          exp_v = sb_q.pop_front();
          checkOutput("fifo_entry", got, exp_v);
        end
        @(negedge clk);
        mon_rd = 1'b0; mon_busy = 1'b0;
        @(negedge clk);
      end
    end
  end

  // Hard stop in case something stalls the whole run
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    int          kind;
    tests = 0; fails = 0;
    rst = 1'b0; kclk = 1'b1; kdata = 1'b1;
    stim_a = 2'd0; stim_rd = 1'b0; d = '0; we = 1'b0; mon_en = 1'b0;
    modelReset();
    repeat (5) @(negedge clk);

    // Reset values of the register window
    checkStatus("reset_status");
    busRead(2'd0, v); checkOutput("reset_data", v, 32'h0);
    busRead(2'd2, v); checkOutput("reset_ctrl", v, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    busWrite(2'd2, 32'h1);

    // Single make code raises the interrupt
    sendByte(8'h1C, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("irq_level", {31'b0, irq}, 32'h1);
    checkStatus("one_entry");
    drain();
    checkOutput("irq_clear", {31'b0, irq}, 32'h0);

    // Extended break sequence folds into one event
    mon_en = 1'b1;
    sendByte(8'hE0, 1'b0, 1'b0);
    sendByte(8'hF0, 1'b0, 1'b0);
    sendByte(8'h74, 1'b0, 1'b0);
    drain();
    busRead(2'd0, v); checkOutput("empty_data", v, 32'h0);

    // Fill past capacity without reading
    for (int i = 0; i < 17; i++) sendByte(8'h15, 1'b0, 1'b0);
    checkStatus("overflow_status");
    busWrite(2'd1, 32'h4);
    m_ovf = 1'b0;
    checkStatus("ovf_cleared");
    drain();

    // Flush empties the FIFO and forgets a pending prefix
    sendByte(8'h11, 1'b0, 1'b0);
    sendByte(8'h22, 1'b0, 1'b0);
    sendByte(8'hE0, 1'b0, 1'b0);
    checkStatus("pre_flush");
    busWrite(2'd2, 32'h3);
    sb_q.delete(); m_ext = 1'b0; m_brk = 1'b0;
    checkStatus("post_flush");
    mon_en = 1'b1;
    sendByte(8'h33, 1'b0, 1'b0);
    drain();

    // Partial frame abandoned by the stall timeout
    mon_en = 1'b1;
    applyStimulus(8'h5A, 1'b0, 1'b0, 5);
    repeat (TOUT + 10) @(posedge clk);
    sendByte(8'h1C, 1'b0, 1'b0);
    drain();
    checkStatus("after_timeout");

    // Wrong parity bit
    mon_en = 1'b1;
    sendByte(8'h1C, 1'b1, 1'b0);
    drain();
    checkStatus("parity_status");
    busWrite(2'd1, 32'h8);
    m_perr = 1'b0;

    // Random mix of codes, prefixes and damaged frames
    mon_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      b = 8'($urandom_range(0, 255));
      case (kind)
        0:       sendByte(8'hE0, 1'b0, 1'b0);
        1:       sendByte(8'hF0, 1'b0, 1'b0);
        2:       sendByte(8'hE1, 1'b0, 1'b0);
        3:       sendByte(b, 1'b0, 1'b1);
        4:       sendByte(b, 1'b1, 1'b0);
        default: sendByte(b, 1'b0, 1'b0);
      endcase
    end
    drain();
    checkStatus("random_flags");
    busWrite(2'd1, 32'h1C);
    m_ferr = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
    checkStatus("flags_cleared");

    // Reset in the middle of a frame with state everywhere
    sendByte(8'h2B, 1'b0, 1'b0);
    sendByte(8'hE0, 1'b0, 1'b0);
    sendByte(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h3C, 1'b0, 1'b0, 5);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkStatus("midframe_reset_status");
    busRead(2'd0, v); checkOutput("midframe_reset_data", v, 32'h0);
    busRead(2'd2, v); checkOutput("midframe_reset_ctrl", v, 32'h0);
    checkOutput("midframe_reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    busWrite(2'd2, 32'h1);
    mon_en = 1'b1;
    sendByte(8'h1C, 1'b0, 1'b0);
    drain();
    checkStatus("post_reset_status");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
